jk_reg_ctrl: RTL and testbench

- Command-driven sequencer for a WIDTH-bit register built from JK flip-flop cells.
- Translates operations into per-bit J/K drive: hold, clear, set, toggle-mask, load, and multi-step count up/down.
- Sits between a command source with a valid/ready handshake and the JK register bank.
- Exposes the J/K drive and register state Q for observation.

---
 rtl/jk_reg_ctrl.sv | 155 +++++++++++++++
 tb/tb_jk_reg_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_ctrl.sv
// Command sequencer driving a bank of WIDTH JK flip-flop cells.
// Translates hold/clear/set/toggle/load/count commands into per-bit J/K drive.
module jk_reg_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Cmd_valid,
    output logic             Cmd_ready,
    input  logic [2:0]       Cmd_op,
    input  logic [WIDTH-1:0] Cmd_data,
    input  logic [CNT_W-1:0] Cmd_steps,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] j_drv, k_drv;

    // Bit i toggles when every lower bit is 1 (counting up).
    function automatic logic [WIDTH-1:0] up_mask(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] m;
        logic             acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = acc;
            acc  = acc & q[i];
        end
        return m;
    endfunction

    // Bit i toggles when every lower bit is 0 (counting down).
    function automatic logic [WIDTH-1:0] down_mask(input logic [WIDTH-1:0] q);
        logic [WIDTH-1:0] m;
        logic             acc;
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = acc;
            acc  = acc & ~q[i];
        end
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
        return (j & ~q) | (~k & q);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        j_drv   = '0;
        k_drv   = '0;
        case (state_q)
            S_IDLE: begin
                if (Cmd_valid) begin
                    op_d   = Cmd_op;
                    data_d = Cmd_data;
                    cnt_d  = Cmd_steps;
                    if (Cmd_op == OP_UP || Cmd_op == OP_DOWN) begin
                        state_d = (Cmd_steps != '0) ? S_COUNT : S_DONE;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_APPLY: begin
                case (op_q)
                    OP_CLEAR:  k_drv = {WIDTH{1'b1}};
                    OP_SET:    j_drv = {WIDTH{1'b1}};
                    OP_TOGGLE: begin
                        j_drv = data_q;
                        k_drv = data_q;
                    end
                    OP_LOAD: begin
                        j_drv = data_q;
                        k_drv = ~data_q;
                    end
                    default: begin
                        j_drv = '0;
                        k_drv = '0;
                    end
                endcase
                state_d = S_DONE;
            end
            S_COUNT: begin
                j_drv   = (op_q == OP_UP) ? up_mask(q_q) : down_mask(q_q);
                k_drv   = j_drv;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        q_d = jk_next(q_q, j_drv, k_drv);
    end

    // Reset aborts anything in flight, so an interrupted command never reaches DONE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_HOLD;
            data_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign Cmd_ready = (state_q == S_IDLE) && !Rst;
    assign J         = Rst ? '0 : j_drv;
    assign K         = Rst ? '0 : k_drv;
    assign Q         = q_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = (state_q == S_DONE);
    assign Err       = (state_q == S_DONE) && (op_q == OP_RSVD);

endmodule

// File: tb/tb_jk_reg_ctrl.sv
// Scoreboard bench for jk_reg_ctrl: driver queues expected completions,
// a monitor pops and checks them on every Done pulse.
module tb_jk_reg_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Cmd_valid;
    logic       Cmd_ready;
    logic [2:0] Cmd_op;
    logic [3:0] Cmd_data;
    logic [7:0] Cmd_steps;
    logic [3:0] J, K, Q;
    logic       Busy, Done, Err;

    typedef struct packed {
        logic [3:0] q;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    jk_reg_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready),
        .Cmd_op(Cmd_op), .Cmd_data(Cmd_data), .Cmd_steps(Cmd_steps),
        .J(J), .K(K), .Q(Q), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got Done=1 Q=%0h expected no completion", Q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (Q !== e.q || Err !== e.err) begin
                    errors++;
                    $display("FAIL done_result: got Q=%0h Err=%0b expected Q=%0h Err=%0b",
                             Q, Err, e.q, e.err);
                end
            end
        end else if (Err) begin
            errors++;
            $display("FAIL err_without_done: got Err=1 expected 0");
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] data, input logic [7:0] steps);
        int n;
        @(negedge Clk);
        Cmd_valid = 1'b1;
        Cmd_op    = op;
        Cmd_data  = data;
        Cmd_steps = steps;
        n = 0;
        while (!Cmd_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_timeout: got Cmd_ready=0 expected 1");
        end
        @(posedge Clk);
        #1;
        Cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (Busy && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL idle_timeout: got Busy=1 expected 0");
        end
    endtask

    task automatic apply_chk(input string name, input logic [2:0] op, input logic [3:0] data,
                             input logic [3:0] ej, input logic [3:0] ek,
                             input logic [3:0] eq, input logic eerr);
        sb.push_back('{q: eq, err: eerr});
        send(op, data, 8'd0);
        chk({name, "_busy"}, 32'(Busy), 32'd1);
        chk({name, "_J"}, 32'(J), 32'(ej));
        chk({name, "_K"}, 32'(K), 32'(ek));
        @(posedge Clk);
        #1;
        chk({name, "_Q"}, 32'(Q), 32'(eq));
        wait_idle();
    endtask

    task automatic step_chk(input string name, input logic [3:0] eq);
        @(posedge Clk);
        #1;
        chk(name, 32'(Q), 32'(eq));
        chk({name, "_busy"}, 32'(Busy), 32'd1);
    endtask

    initial begin
        Rst       = 1'b1;
        Cmd_valid = 1'b1;
        Cmd_op    = 3'd2;
        Cmd_data  = 4'h0;
        Cmd_steps = 8'd0;

        // Reset with a command pending: nothing may be accepted.
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        chk("rst_Q", 32'(Q), 32'h0);
        chk("rst_ready", 32'(Cmd_ready), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_J", 32'(J), 32'h0);
        Rst       = 1'b0;
        Cmd_valid = 1'b0;
        @(negedge Clk);
        chk("rel_ready", 32'(Cmd_ready), 32'd1);
        chk("rel_Q", 32'(Q), 32'h0);

        apply_chk("set",    3'd2, 4'h0, 4'hF, 4'h0, 4'hF, 1'b0);
        apply_chk("clear",  3'd1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
        apply_chk("load_a", 3'd4, 4'hA, 4'hA, 4'h5, 4'hA, 1'b0);
        apply_chk("toggle", 3'd3, 4'h6, 4'h6, 4'h6, 4'hC, 1'b0);
        apply_chk("hold",   3'd0, 4'h9, 4'h0, 4'h0, 4'hC, 1'b0);
        apply_chk("op7",    3'd7, 4'h3, 4'h0, 4'h0, 4'hC, 1'b1);

        // Count up across the wrap, then back down across it.
        apply_chk("load_e", 3'd4, 4'hE, 4'hE, 4'h1, 4'hE, 1'b0);
        sb.push_back('{q: 4'h1, err: 1'b0});
        send(3'd5, 4'h0, 8'd3);
        chk("up_J0", 32'(J), 32'h1);
        step_chk("up_s1", 4'hF);
        step_chk("up_s2", 4'h0);
        step_chk("up_s3", 4'h1);
        chk("up_done", 32'(Done), 32'd1);
        wait_idle();
        sb.push_back('{q: 4'hF, err: 1'b0});
        send(3'd6, 4'h0, 8'd2);
        step_chk("dn_s1", 4'h0);
        step_chk("dn_s2", 4'hF);
        wait_idle();

        // Command held valid while busy: second one only accepted back in IDLE.
        sb.push_back('{q: 4'h5, err: 1'b0});
        sb.push_back('{q: 4'hA, err: 1'b0});
        send(3'd4, 4'h5, 8'd0);
        Cmd_valid = 1'b1;
        Cmd_op    = 3'd3;
        Cmd_data  = 4'hF;
        chk("held_J", 32'(J), 32'h5);
        @(posedge Clk);
        #1;
        chk("held_Q1", 32'(Q), 32'h5);
        chk("held_ready_done", 32'(Cmd_ready), 32'd0);
        @(posedge Clk);
        #1;
        chk("held_idle_ready", 32'(Cmd_ready), 32'd1);
        chk("held_Q2", 32'(Q), 32'h5);
        @(posedge Clk);
        #1;
        Cmd_valid = 1'b0;
        chk("held_apply_J", 32'(J), 32'hF);
        @(posedge Clk);
        #1;
        chk("held_Q3", 32'(Q), 32'hA);
        wait_idle();

        // Zero-step count completes immediately with Q untouched.
        sb.push_back('{q: 4'hA, err: 1'b0});
        send(3'd5, 4'h0, 8'd0);
        chk("zero_done", 32'(Done), 32'd1);
        chk("zero_Q", 32'(Q), 32'hA);
        wait_idle();

        // Reset in the middle of a long count: no completion.
        apply_chk("clr2", 3'd1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0);
        send(3'd5, 4'h0, 8'd10);
        step_chk("abort_s1", 4'h1);
        step_chk("abort_s2", 4'h2);
        step_chk("abort_s3", 4'h3);
        step_chk("abort_s4", 4'h4);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("abort_Q", 32'(Q), 32'h0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_ready_rst", 32'(Cmd_ready), 32'd0);
        Rst = 1'b0;
        #1;
        chk("abort_ready_rel", 32'(Cmd_ready), 32'd1);
        apply_chk("load_3", 3'd4, 4'h3, 4'h3, 4'hC, 4'h3, 1'b0);

        repeat (3) @(negedge Clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
